// File: rtl/decode_ctrl_stage_pkg.sv
// Shared definitions for the decode/control stage: opcodes, ALU ops,
// branch/jump encodings, FSM states and the control-word layout.
package decode_ctrl_stage_pkg;

  localparam int INSN_W_DEF     = 32;
  localparam int OPCODE_W_DEF   = 5;
  localparam int ALUOP_W_DEF    = 5;
  localparam int MD_TIMEOUT_DEF = 64;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_J     = 5'b00001;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] OP_BEX   = 5'b10110;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  typedef enum logic [1:0] {BR_NONE, BR_BNE, BR_BLT, BR_BEX} branch_t;
  typedef enum logic [1:0] {JMP_NONE, JMP_J, JMP_JAL, JMP_JR} jump_t;
  typedef enum logic {ST_IDLE, ST_MD_WAIT} state_t;

  typedef struct packed {
    logic       reg_we;
    logic       use_imm;
    logic       read_rd;
    logic       mem_we;
    logic       mem_to_reg;
    branch_t    branch;
    jump_t      jump;
    logic [4:0] alu_op;
    logic       is_md;
    logic       setx;
  } ctrl_word_t;

  function automatic logic isMdOp(input logic [4:0] aluOp);
    return (aluOp == ALU_MUL) || (aluOp == ALU_DIV);
  endfunction

endpackage

// File: rtl/decode_ctrl_stage_if.sv
// Bundle of the stage's handshake, multdiv and control-word signals.
// master = upstream/execute side, slave = the decode/control stage.
interface decode_ctrl_stage_if
  import decode_ctrl_stage_pkg::*;
#(
  parameter int INSN_W  = INSN_W_DEF,
  parameter int ALUOP_W = ALUOP_W_DEF
);
  logic               in_valid;
  logic               in_ready;
  logic [INSN_W-1:0]  in_insn;
  logic               flush;
  logic               md_start;
  logic               md_ready;
  logic               out_valid;
  logic               out_ready;
  logic               reg_we;
  logic               use_imm;
  logic               read_rd;
  logic               mem_we;
  logic               mem_to_reg;
  logic [1:0]         branch;
  logic [1:0]         jump;
  logic [ALUOP_W-1:0] alu_op;
  logic               is_md;
  logic               setx;
  logic               md_timeout;

  modport master (
    output in_valid, in_insn, flush, md_ready, out_ready,
    input  in_ready, md_start, out_valid, reg_we, use_imm, read_rd, mem_we,
           mem_to_reg, branch, jump, alu_op, is_md, setx, md_timeout
  );

  modport slave (
    input  in_valid, in_insn, flush, md_ready, out_ready,
    output in_ready, md_start, out_valid, reg_we, use_imm, read_rd, mem_we,
           mem_to_reg, branch, jump, alu_op, is_md, setx, md_timeout
  );
endinterface

// File: rtl/decode_ctrl_stage_decode.sv
// Purely combinational opcode -> control word decoder.
// Undefined opcodes yield an all-zero word, which behaves as a nop.
module decode_ctrl_stage_decode
  import decode_ctrl_stage_pkg::*;
#(
  parameter int OPCODE_W = OPCODE_W_DEF,
  parameter int ALUOP_W  = ALUOP_W_DEF
) (
  input  logic [OPCODE_W-1:0] opcode_i,
  input  logic [ALUOP_W-1:0]  aluField_i,
  output ctrl_word_t          ctrlWord_o
);

  always_comb begin
    ctrlWord_o = '0;
    case (opcode_i)
      OP_RTYPE: begin
        ctrlWord_o.reg_we = 1'b1;
        ctrlWord_o.alu_op = aluField_i;
        ctrlWord_o.is_md  = isMdOp(aluField_i);
      end
      OP_ADDI: begin
        ctrlWord_o.reg_we  = 1'b1;
        ctrlWord_o.use_imm = 1'b1;
        ctrlWord_o.alu_op  = ALU_ADD;
      end
      OP_SW: begin
        ctrlWord_o.use_imm = 1'b1;
        ctrlWord_o.read_rd = 1'b1;
        ctrlWord_o.mem_we  = 1'b1;
        ctrlWord_o.alu_op  = ALU_ADD;
      end
      OP_LW: begin
        ctrlWord_o.reg_we     = 1'b1;
        ctrlWord_o.use_imm    = 1'b1;
        ctrlWord_o.mem_to_reg = 1'b1;
        ctrlWord_o.alu_op     = ALU_ADD;
      end
      OP_J: ctrlWord_o.jump = JMP_J;
      OP_JAL: begin
        ctrlWord_o.jump   = JMP_JAL;
        ctrlWord_o.reg_we = 1'b1;
      end
      OP_JR: begin
        ctrlWord_o.jump    = JMP_JR;
        ctrlWord_o.read_rd = 1'b1;
      end
      // Compare-branches subtract rs - rd to set the ALU flags.
      OP_BNE: begin
        ctrlWord_o.branch  = BR_BNE;
        ctrlWord_o.read_rd = 1'b1;
        ctrlWord_o.alu_op  = ALU_SUB;
      end
      OP_BLT: begin
        ctrlWord_o.branch  = BR_BLT;
        ctrlWord_o.read_rd = 1'b1;
        ctrlWord_o.alu_op  = ALU_SUB;
      end
      OP_BEX: ctrlWord_o.branch = BR_BEX;
      OP_SETX: begin
        ctrlWord_o.setx   = 1'b1;
        ctrlWord_o.reg_we = 1'b1;
      end
      default: ctrlWord_o = '0;
    endcase
  end

endmodule

// File: rtl/decode_ctrl_stage.sv
// Registered decode/control stage: pipeline register with valid/ready and
// flush, plus a multdiv issue/wait FSM guarded by a timeout watchdog.
module decode_ctrl_stage
  import decode_ctrl_stage_pkg::*;
#(
  parameter int INSN_W     = INSN_W_DEF,
  parameter int OPCODE_W   = OPCODE_W_DEF,
  parameter int ALUOP_W    = ALUOP_W_DEF,
  parameter int MD_TIMEOUT = MD_TIMEOUT_DEF
) (
  input  logic                 clock,
  input  logic                 reset_n,
  decode_ctrl_stage_if.slave   bus
);

  localparam int              CNT_W    = $clog2(MD_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);

  ctrl_word_t       ctrlWord_d;
  ctrl_word_t       ctrlWord_q;
  state_t           state_q;
  logic             outValid_q;
  logic             mdStart_q;
  logic             timeout_q;
  logic [CNT_W-1:0] waitCnt_q;
  logic             inReady;
  logic             accept;
  logic             unusedInsn;

  decode_ctrl_stage_decode #(
    .OPCODE_W (OPCODE_W),
    .ALUOP_W  (ALUOP_W)
  ) u_decode (
    .opcode_i   (bus.in_insn[INSN_W-1 -: OPCODE_W]),
    .aluField_i (bus.in_insn[ALUOP_W+1:2]),
    .ctrlWord_o (ctrlWord_d)
  );

  assign unusedInsn = ^{bus.in_insn[INSN_W-OPCODE_W-1:ALUOP_W+2], bus.in_insn[1:0]};

  assign inReady = (state_q == ST_IDLE) & ~bus.flush & (~outValid_q | bus.out_ready);
  assign accept  = bus.in_valid & inReady;

  // Flush outranks everything; in MD_WAIT md_ready outranks the watchdog,
  // and a timed-out multdiv still retires, but without a register write.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      ctrlWord_q <= '0;
      outValid_q <= 1'b0;
      mdStart_q  <= 1'b0;
      timeout_q  <= 1'b0;
      waitCnt_q  <= '0;
    end else if (bus.flush) begin
      state_q    <= ST_IDLE;
      outValid_q <= 1'b0;
      mdStart_q  <= 1'b0;
      waitCnt_q  <= '0;
    end else begin
      mdStart_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            ctrlWord_q <= ctrlWord_d;
            waitCnt_q  <= '0;
            if (ctrlWord_d.is_md) begin
              state_q    <= ST_MD_WAIT;
              mdStart_q  <= 1'b1;
              outValid_q <= 1'b0;
            end else begin
              outValid_q <= 1'b1;
            end
          end else if (bus.out_ready) begin
            outValid_q <= 1'b0;
          end
        end
        ST_MD_WAIT: begin
          if (bus.md_ready) begin
            outValid_q <= 1'b1;
            state_q    <= ST_IDLE;
            waitCnt_q  <= '0;
          end else if (waitCnt_q == CNT_LAST) begin
            ctrlWord_q.reg_we <= 1'b0;
            timeout_q         <= 1'b1;
            outValid_q        <= 1'b1;
            state_q           <= ST_IDLE;
            waitCnt_q         <= '0;
          end else begin
            waitCnt_q <= waitCnt_q + CNT_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = inReady;
  assign bus.md_start   = mdStart_q;
  assign bus.out_valid  = outValid_q;
  assign bus.reg_we     = ctrlWord_q.reg_we;
  assign bus.use_imm    = ctrlWord_q.use_imm;
  assign bus.read_rd    = ctrlWord_q.read_rd;
  assign bus.mem_we     = ctrlWord_q.mem_we;
  assign bus.mem_to_reg = ctrlWord_q.mem_to_reg;
  assign bus.branch     = ctrlWord_q.branch;
  assign bus.jump       = ctrlWord_q.jump;
  assign bus.alu_op     = ctrlWord_q.alu_op;
  assign bus.is_md      = ctrlWord_q.is_md;
  assign bus.setx       = ctrlWord_q.setx;
  assign bus.md_timeout = timeout_q;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Testbench for decode_ctrl_stage: decode table, multi-cycle corner cases
// and a randomized run against a transaction-level reference model.
module tb_decode_ctrl_stage;

  localparam int LONG_T  = 64;
  localparam int SHORT_T = 8;
  localparam int RAND_CYCLES = 1500;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  decode_ctrl_stage_if bus ();
  decode_ctrl_stage_if bus8 ();

  decode_ctrl_stage #(.MD_TIMEOUT(LONG_T)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  decode_ctrl_stage #(.MD_TIMEOUT(SHORT_T)) dut8 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus8)
  );

  typedef struct packed {
    logic       regWe;
    logic       useImm;
    logic       readRd;
    logic       memWe;
    logic       memToReg;
    logic [1:0] branch;
    logic [1:0] jump;
    logic [4:0] aluOp;
    logic       isMd;
    logic       setx;
  } cw_t;

  typedef struct {
    logic [31:0] insn;
    cw_t         expWord;
  } vec_t;

  cw_t dutWord;
  cw_t dut8Word;
  assign dutWord  = {bus.reg_we, bus.use_imm, bus.read_rd, bus.mem_we, bus.mem_to_reg,
                     bus.branch, bus.jump, bus.alu_op, bus.is_md, bus.setx};
  assign dut8Word = {bus8.reg_we, bus8.use_imm, bus8.read_rd, bus8.mem_we, bus8.mem_to_reg,
                     bus8.branch, bus8.jump, bus8.alu_op, bus8.is_md, bus8.setx};

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic [31:0] insn, input logic ordy,
                               input logic fl, input logic mdr);
    bus.in_valid  = iv;
    bus.in_insn   = insn;
    bus.out_ready = ordy;
    bus.flush     = fl;
    bus.md_ready  = mdr;
  endtask

  function automatic cw_t mk(input logic rw, input logic ui, input logic rr, input logic mw,
                             input logic mr, input logic [1:0] br, input logic [1:0] jp,
                             input logic [4:0] alu, input logic md, input logic sx);
    return {rw, ui, rr, mw, mr, br, jp, alu, md, sx};
  endfunction

  // Instruction-set table: what each mnemonic asks of the datapath.
  function automatic cw_t refDecode(input logic [31:0] insn);
    logic [4:0] op;
    logic [4:0] fn;
    op = insn[31:27];
    fn = insn[6:2];
    case (op)
      5'd0:    return mk(1, 0, 0, 0, 0, 2'd0, 2'd0, fn, (fn == 5'd6) || (fn == 5'd7), 0);
      5'd5:    return mk(1, 1, 0, 0, 0, 2'd0, 2'd0, 5'd0, 0, 0);
      5'd7:    return mk(0, 1, 1, 1, 0, 2'd0, 2'd0, 5'd0, 0, 0);
      5'd8:    return mk(1, 1, 0, 0, 1, 2'd0, 2'd0, 5'd0, 0, 0);
      5'd1:    return mk(0, 0, 0, 0, 0, 2'd0, 2'd1, 5'd0, 0, 0);
      5'd2:    return mk(0, 0, 1, 0, 0, 2'd1, 2'd0, 5'd1, 0, 0);
      5'd3:    return mk(1, 0, 0, 0, 0, 2'd0, 2'd2, 5'd0, 0, 0);
      5'd4:    return mk(0, 0, 1, 0, 0, 2'd0, 2'd3, 5'd0, 0, 0);
      5'd6:    return mk(0, 0, 1, 0, 0, 2'd2, 2'd0, 5'd1, 0, 0);
      5'd22:   return mk(0, 0, 0, 0, 0, 2'd3, 2'd0, 5'd0, 0, 0);
      5'd21:   return mk(1, 0, 0, 0, 0, 2'd0, 2'd0, 5'd0, 0, 1);
      default: return '0;
    endcase
  endfunction

  // Reference model state, transaction level: cycle stamps instead of counters.
  int  cyc;
  bit  mOutValid;
  bit  mWaiting;
  int  mIssue;
  cw_t mWord;
  bit  mStartPulse;
  bit  mTimeout;

  initial begin
    vec_t        vecs[13];
    logic        iv, ordy, fl, mdr, expReady;
    logic [31:0] insn;

    vecs[0]  = '{32'h28400005, mk(1, 1, 0, 0, 0, 2'd0, 2'd0, 5'd0, 0, 0)};
    vecs[1]  = '{32'h00000004, mk(1, 0, 0, 0, 0, 2'd0, 2'd0, 5'd1, 0, 0)};
    vecs[2]  = '{32'h00421008, mk(1, 0, 0, 0, 0, 2'd0, 2'd0, 5'd2, 0, 0)};
    vecs[3]  = '{32'h38000000, mk(0, 1, 1, 1, 0, 2'd0, 2'd0, 5'd0, 0, 0)};
    vecs[4]  = '{32'h40000000, mk(1, 1, 0, 0, 1, 2'd0, 2'd0, 5'd0, 0, 0)};
    vecs[5]  = '{32'h08000010, mk(0, 0, 0, 0, 0, 2'd0, 2'd1, 5'd0, 0, 0)};
    vecs[6]  = '{32'h1000007C, mk(0, 0, 1, 0, 0, 2'd1, 2'd0, 5'd1, 0, 0)};
    vecs[7]  = '{32'h18000000, mk(1, 0, 0, 0, 0, 2'd0, 2'd2, 5'd0, 0, 0)};
    vecs[8]  = '{32'h20000000, mk(0, 0, 1, 0, 0, 2'd0, 2'd3, 5'd0, 0, 0)};
    vecs[9]  = '{32'h30000000, mk(0, 0, 1, 0, 0, 2'd2, 2'd0, 5'd1, 0, 0)};
    vecs[10] = '{32'hB0000000, mk(0, 0, 0, 0, 0, 2'd3, 2'd0, 5'd0, 0, 0)};
    vecs[11] = '{32'hA8000000, mk(1, 0, 0, 0, 0, 2'd0, 2'd0, 5'd0, 0, 1)};
    vecs[12] = '{32'hF8000018, '0};

    applyStimulus(0, 32'h0, 0, 0, 0);
    bus8.in_valid = 0; bus8.in_insn = 32'h0; bus8.out_ready = 1;
    bus8.flush = 0; bus8.md_ready = 0;

    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    checkOutput("rst in_ready", bus.in_ready, 1);
    checkOutput("rst out_valid", bus.out_valid, 0);
    checkOutput("rst md_start", bus.md_start, 0);
    checkOutput("rst md_timeout", bus.md_timeout, 0);
    checkOutput("rst word", dutWord, 0);
    reset_n = 1'b1;

    // Decode table, issued back to back with out_ready high.
    for (int i = 0; i < 13; i++) begin
      @(negedge clock);
      applyStimulus(1, vecs[i].insn, 1, 0, 0);
      #1 checkOutput($sformatf("vec%0d in_ready", i), bus.in_ready, 1);
      @(posedge clock);
      #1;
      checkOutput($sformatf("vec%0d out_valid", i), bus.out_valid, 1);
      checkOutput($sformatf("vec%0d word", i), dutWord, vecs[i].expWord);
    end
    @(negedge clock);
    applyStimulus(0, 32'h0, 1, 0, 0);
    @(posedge clock);
    #1 checkOutput("drain out_valid", bus.out_valid, 0);

    // mul: one md_start pulse, 10 wait cycles, then md_ready.
    @(negedge clock);
    applyStimulus(1, 32'h00C22018, 1, 0, 0);
    @(posedge clock);
    #1;
    checkOutput("mul md_start", bus.md_start, 1);
    checkOutput("mul out_valid", bus.out_valid, 0);
    checkOutput("mul in_ready", bus.in_ready, 0);
    @(negedge clock);
    applyStimulus(0, 32'h0, 1, 0, 0);
    for (int k = 0; k < 10; k++) begin
      @(posedge clock);
      #1;
      checkOutput("mul wait md_start", bus.md_start, 0);
      checkOutput("mul wait out_valid", bus.out_valid, 0);
      checkOutput("mul wait in_ready", bus.in_ready, 0);
    end
    @(negedge clock);
    applyStimulus(0, 32'h0, 1, 0, 1);
    @(posedge clock);
    #1;
    checkOutput("mul done out_valid", bus.out_valid, 1);
    checkOutput("mul done word", dutWord, mk(1, 0, 0, 0, 0, 2'd0, 2'd0, 5'd6, 1, 0));
    checkOutput("mul done in_ready", bus.in_ready, 1);
    @(negedge clock);
    applyStimulus(0, 32'h0, 1, 0, 0);
    @(posedge clock);
    #1 checkOutput("mul retire out_valid", bus.out_valid, 0);

    // sw held under backpressure; an addi waits upstream and must not enter.
    @(negedge clock);
    applyStimulus(1, 32'h38000000, 0, 0, 0);
    @(posedge clock);
    #1 checkOutput("sw out_valid", bus.out_valid, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      applyStimulus(1, 32'h28400005, 0, 0, 0);
      #1 checkOutput("hold in_ready", bus.in_ready, 0);
      @(posedge clock);
      #1;
      checkOutput("hold out_valid", bus.out_valid, 1);
      checkOutput("hold word", dutWord, mk(0, 1, 1, 1, 0, 2'd0, 2'd0, 5'd0, 0, 0));
    end
    @(negedge clock);
    applyStimulus(0, 32'h0, 1, 0, 0);
    @(posedge clock);
    #1 checkOutput("hold release out_valid", bus.out_valid, 0);

    // Flush during MD_WAIT with md_ready in the same cycle.
    @(negedge clock);
    applyStimulus(1, 32'h0000001C, 1, 0, 0);
    @(posedge clock);
    #1 checkOutput("div md_start", bus.md_start, 1);
    @(negedge clock);
    applyStimulus(1, 32'h28400005, 1, 1, 1);
    #1 checkOutput("flush in_ready", bus.in_ready, 0);
    @(posedge clock);
    #1;
    checkOutput("flush out_valid", bus.out_valid, 0);
    checkOutput("flush md_start", bus.md_start, 0);
    @(negedge clock);
    applyStimulus(1, 32'h28400005, 1, 0, 0);
    #1 checkOutput("post-flush in_ready", bus.in_ready, 1);
    @(posedge clock);
    #1;
    checkOutput("post-flush out_valid", bus.out_valid, 1);
    checkOutput("post-flush word", dutWord, mk(1, 1, 0, 0, 0, 2'd0, 2'd0, 5'd0, 0, 0));
    @(negedge clock);
    applyStimulus(0, 32'h0, 1, 0, 0);

    // Short watchdog: md_ready on the last wait cycle wins, then a real timeout.
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clock);
      bus8.in_valid = 1; bus8.in_insn = 32'h0000001C; bus8.md_ready = 0;
      @(posedge clock);
      #1 checkOutput("t8 md_start", bus8.md_start, 1);
      @(negedge clock);
      bus8.in_valid = 0;
      for (int k = 1; k < SHORT_T; k++) begin
        @(posedge clock);
        #1 checkOutput("t8 wait out_valid", bus8.out_valid, 0);
        @(negedge clock);
      end
      bus8.md_ready = (pass == 0);
      @(posedge clock);
      #1;
      checkOutput("t8 out_valid", bus8.out_valid, 1);
      checkOutput("t8 reg_we", bus8.reg_we, (pass == 0) ? 1 : 0);
      checkOutput("t8 md_timeout", bus8.md_timeout, (pass == 0) ? 0 : 1);
      checkOutput("t8 is_md", dut8Word.isMd, 1);
      @(negedge clock);
      bus8.md_ready = 0;
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clock);
      #1 checkOutput("t8 sticky", bus8.md_timeout, 1);
    end

    // Asynchronous reset in the middle of a cycle: held word, then MD_WAIT.
    @(negedge clock);
    applyStimulus(1, 32'h38000000, 0, 0, 0);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("arst held out_valid", bus.out_valid, 0);
    checkOutput("arst held word", dutWord, 0);
    checkOutput("arst in_ready", bus.in_ready, 1);
    checkOutput("arst sticky clear", bus8.md_timeout, 0);
    @(negedge clock);
    reset_n = 1'b1;
    applyStimulus(1, 32'h00C22018, 1, 0, 0);
    @(posedge clock);
    #2 checkOutput("arst md_start pre", bus.md_start, 1);
    reset_n = 1'b0;
    #1;
    checkOutput("arst md_start", bus.md_start, 0);
    checkOutput("arst md out_valid", bus.out_valid, 0);
    @(negedge clock);
    reset_n = 1'b1;
    applyStimulus(0, 32'h0, 1, 0, 0);
    #1 checkOutput("arst release in_ready", bus.in_ready, 1);

    // Randomized run against the reference model.
    cyc = 0; mOutValid = 0; mWaiting = 0; mIssue = 0;
    mWord = '0; mStartPulse = 0; mTimeout = 0;
    for (int n = 0; n < RAND_CYCLES; n++) begin
      @(negedge clock);
      iv   = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 7);
      fl   = ($urandom_range(0, 19) == 0);
      mdr  = ($urandom_range(0, 4) == 0);
      insn = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        insn[31:27] = 5'd0;
        insn[6:2]   = 5'($urandom_range(6, 7));
      end
      applyStimulus(iv, insn, ordy, fl, mdr);
      #1;
      expReady = !mWaiting && !fl && (!mOutValid || ordy);
      checkOutput("rand in_ready", bus.in_ready, expReady);
      checkOutput("rand out_valid", bus.out_valid, mOutValid);
      checkOutput("rand md_start", bus.md_start, mStartPulse);
      checkOutput("rand md_timeout", bus.md_timeout, mTimeout);
      if (mOutValid) checkOutput("rand word", dutWord, mWord);
      @(posedge clock);
      if (fl) begin
        mOutValid = 0; mWaiting = 0; mStartPulse = 0;
      end else begin
        mStartPulse = 0;
        if (mWaiting) begin
          if (mdr) begin
            mOutValid = 1; mWaiting = 0;
          end else if (cyc - mIssue == LONG_T) begin
            mOutValid = 1; mWaiting = 0; mTimeout = 1; mWord.regWe = 0;
          end
        end else if (iv && expReady) begin
          mWord = refDecode(insn);
          if (mWord.isMd) begin
            mWaiting = 1; mIssue = cyc; mStartPulse = 1; mOutValid = 0;
          end else begin
            mOutValid = 1;
          end
        end else if (ordy) begin
          mOutValid = 0;
        end
      end
      cyc++;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
